spi_boot_master: RTL and testbench

- APB responder peripheral that drives the SPI slave port of the on-chip bootloader: MOSI, SCLK, PROG and BRSTn.
- A host-side or test CPU writes a start address once, then writes data words.
- Each data write is serialized as one 24-bit frame {addr[7:0], data[15:0]}, MSB first, SPI mode 0. The address auto-increments after every frame.
- Sits on the APB bus next to APB_MEM_CONTROL-style responders. Used for in-system reprogramming and as the bench driver for the bootloader.

---
 rtl/spi_boot_master.sv | 152 +++++++++++++++
 tb/tb_spi_boot_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_boot_master.sv
// APB-programmable SPI mode-0 master that feeds {addr, data} frames to the bootloader slave port.
// Address auto-increments per frame; writes stall while a frame or its trailing gap is active.
module spi_boot_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PSel,
    input  logic        PEnable,
    input  logic        PWrite,
    input  logic [15:0] PAddress,
    input  logic [15:0] PWData,
    output logic [15:0] PRData,
    output logic        PReady,
    output logic        PSLERR,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        PROG,
    output logic        BRSTn,
    output logic        BUSY
);

    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} state_e;

    state_e         state_q;
    logic [7:0]     addr_q;
    logic [15:0]    data_q;
    logic [1:0]     ctrl_q;
    logic [15:0]    rx_q;
    logic [15:0]    rxShift_q;
    logic [23:0]    shift_q;
    logic [4:0]     bitCnt_q;
    logic [7:0]     divCnt_q;
    logic [GW-1:0]  gapCnt_q;
    logic           sclk_q;
    logic           mosi_q;
    logic           busy_q;

    logic access;
    logic addrErr;
    logic wrCommit;

    assign access   = PSel & PEnable;
    assign addrErr  = |PAddress[15:2];
    // Any valid write is held off until the frame and its gap have finished.
    assign wrCommit = access & PWrite & ~addrErr & ~busy_q;
    assign PReady   = ~(access & PWrite & ~addrErr & busy_q);
    assign PSLERR   = access & addrErr;

    always_comb begin
        PRData = '0;
        if (access && !PWrite && !addrErr) begin
            case (PAddress[1:0])
                2'd0:    PRData = {8'h00, addr_q};
                2'd1:    PRData = data_q;
                2'd2:    PRData = {7'b0, busy_q, 6'b0, ctrl_q};
                default: PRData = rx_q;
            endcase
        end
    end

    assign SCLK  = sclk_q;
    assign MOSI  = mosi_q;
    assign PROG  = ctrl_q[0];
    assign BRSTn = ~ctrl_q[1];
    assign BUSY  = busy_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            ctrl_q    <= '0;
            rx_q      <= '0;
            rxShift_q <= '0;
            shift_q   <= '0;
            bitCnt_q  <= '0;
            divCnt_q  <= '0;
            gapCnt_q  <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (wrCommit) begin
                case (PAddress[1:0])
                    2'd0:    addr_q <= PWData[7:0];
                    2'd1:    data_q <= PWData;
                    2'd2:    ctrl_q <= PWData[1:0];
                    default: ;
                endcase
            end

            case (state_q)
                IDLE: begin
                    if (wrCommit && PAddress[1:0] == 2'd1) begin
                        shift_q  <= {addr_q, PWData};
                        mosi_q   <= addr_q[7];
                        busy_q   <= 1'b1;
                        divCnt_q <= '0;
                        bitCnt_q <= 5'd23;
                        state_q  <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (divCnt_q == 8'(CLK_DIV - 1)) begin
                        divCnt_q  <= '0;
                        sclk_q    <= 1'b1;
                        rxShift_q <= {rxShift_q[14:0], MISO};
                        state_q   <= SHIFT_HI;
                    end else begin
                        divCnt_q <= divCnt_q + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (divCnt_q == 8'(CLK_DIV - 1)) begin
                        divCnt_q <= '0;
                        sclk_q   <= 1'b0;
                        if (bitCnt_q == 5'd0) begin
                            mosi_q   <= 1'b0;
                            rx_q     <= rxShift_q;
                            addr_q   <= addr_q + 8'd1;
                            gapCnt_q <= '0;
                            state_q  <= GAP;
                        end else begin
                            // Next bit goes out on the same edge SCLK falls.
                            shift_q  <= {shift_q[22:0], 1'b0};
                            mosi_q   <= shift_q[22];
                            bitCnt_q <= bitCnt_q - 5'd1;
                            state_q  <= SHIFT_LO;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (gapCnt_q == GW'(GAP_CYC - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_boot_master.sv
// Directed bench for spi_boot_master: reset, single frame, stalled back-to-back writes,
// address wrap with MISO capture, address error response and reset mid-frame.
module tb_spi_boot_master;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned GAP_CYC = 4;

    logic        CLK;
    logic        RST;
    logic        PSel;
    logic        PEnable;
    logic        PWrite;
    logic [15:0] PAddress;
    logic [15:0] PWData;
    logic [15:0] PRData;
    logic        PReady;
    logic        PSLERR;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        PROG;
    logic        BRSTn;
    logic        BUSY;

    int total = 0;
    int bad = 0;

    logic [23:0] capBits = '0;
    int          bitCnt = 0;
    logic [23:0] frames[$];
    int          lowRun = 0;
    int          gapLow = 0;
    int          busyCycles = 0;
    logic [23:0] misoShift = '0;

    spi_boot_master #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .CLK(CLK), .RST(RST), .PSel(PSel), .PEnable(PEnable), .PWrite(PWrite),
        .PAddress(PAddress), .PWData(PWData), .PRData(PRData), .PReady(PReady),
        .PSLERR(PSLERR), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .PROG(PROG),
        .BRSTn(BRSTn), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SPI slave model: records MOSI on every SCLK rise, collects full frames.
    initial forever begin
        @(posedge SCLK);
        if (bitCnt == 0) gapLow = lowRun;
        capBits = {capBits[22:0], MOSI};
        bitCnt++;
        if (bitCnt == 24) begin
            frames.push_back(capBits);
            bitCnt = 0;
        end
    end

    // Slave presents the next MISO bit after each SCLK fall (mode 0).
    initial forever begin
        @(negedge SCLK);
        misoShift = {misoShift[22:0], 1'b0};
        MISO = misoShift[23];
    end

    initial forever begin
        @(negedge CLK);
        if (BUSY === 1'b1) busyCycles++;
        if (SCLK === 1'b0) lowRun++;
        else lowRun = 0;
    end

    task automatic apbWrite(input logic [15:0] addr, input logic [15:0] data,
                            output int waits, output logic err);
        bit done;
        @(posedge CLK); #1;
        PSel = 1'b1; PEnable = 1'b0; PWrite = 1'b1; PAddress = addr; PWData = data;
        @(posedge CLK); #1;
        PEnable = 1'b1;
        waits = 0; err = 1'b0; done = 1'b0;
        while (!done) begin
            #4;
            if (PReady === 1'b1) begin
                err = PSLERR;
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 400) begin
                    total++; bad++;
                    $display("[TB] FAIL apb_write_timeout addr=%h waits=%0d required<=400", addr, waits);
                    done = 1'b1;
                end else begin
                    @(posedge CLK); #1;
                end
            end
        end
        @(posedge CLK); #1;
        PSel = 1'b0; PEnable = 1'b0; PWrite = 1'b0;
    endtask

    task automatic apbRead(input logic [15:0] addr, output logic [15:0] data, output logic err);
        @(posedge CLK); #1;
        PSel = 1'b1; PEnable = 1'b0; PWrite = 1'b0; PAddress = addr;
        @(posedge CLK); #1;
        PEnable = 1'b1;
        #4;
        data = PRData;
        err = PSLERR;
        total++;
        if (PReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL read_ready addr=%h got=%b want=1", addr, PReady);
        end
        @(posedge CLK); #1;
        PSel = 1'b0; PEnable = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (BUSY === 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s_idle_timeout busy=%b want=0", tag, BUSY);
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        logic        err;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        total++;
        if ({SCLK, MOSI, PROG, BRSTn, PReady, PSLERR, BUSY} !== 7'b0001100) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%b want=0001100",
                     {SCLK, MOSI, PROG, BRSTn, PReady, PSLERR, BUSY});
        end
        total++;
        if (PRData !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_prdata got=%h want=0000", PRData);
        end
        @(negedge CLK);
        RST = 1'b1;
        apbRead(16'h0002, rd, err);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%h want=0000", rd);
        end
        apbRead(16'h0000, rd, err);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_addr got=%h want=0000", rd);
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] rd;
        logic        err;
        int          waits;
        apbWrite(16'h0002, 16'h0001, waits, err);
        total++;
        if ({PROG, BRSTn} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL ctrl_prog got=%b want=11", {PROG, BRSTn});
        end
        apbWrite(16'h0000, 16'h0010, waits, err);
        misoShift = '0; MISO = 1'b0;
        frames.delete(); bitCnt = 0;
        busyCycles = 0;
        apbWrite(16'h0001, 16'hA55A, waits, err);
        waitIdle("single");
        total++;
        if (frames.size() != 1 || frames[0] !== 24'h10A55A) begin
            bad++;
            $display("[TB] FAIL single_frame count=%0d got=%h want=10a55a",
                     frames.size(), (frames.size() > 0) ? frames[0] : 24'h0);
        end
        total++;
        if (busyCycles != 48 * CLK_DIV + GAP_CYC) begin
            bad++;
            $display("[TB] FAIL busy_length got=%0d want=%0d", busyCycles, 48 * CLK_DIV + GAP_CYC);
        end
        apbRead(16'h0000, rd, err);
        total++;
        if (rd !== 16'h0011) begin
            bad++;
            $display("[TB] FAIL addr_incr got=%h want=0011", rd);
        end
        apbRead(16'h0001, rd, err);
        total++;
        if (rd !== 16'hA55A) begin
            bad++;
            $display("[TB] FAIL data_readback got=%h want=a55a", rd);
        end
        apbRead(16'h0002, rd, err);
        total++;
        if (rd !== 16'h0001) begin
            bad++;
            $display("[TB] FAIL ctrl_readback got=%h want=0001", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd;
        logic        err;
        int          waits1;
        int          waits2;
        frames.delete(); bitCnt = 0;
        apbWrite(16'h0001, 16'h0001, waits1, err);
        apbWrite(16'h0001, 16'h0002, waits2, err);
        total++;
        if (waits1 != 0) begin
            bad++;
            $display("[TB] FAIL b2b_first_waits got=%0d want=0", waits1);
        end
        // Access phase starts two cycles after the first commit; 100 busy cycles leave 98 stalls.
        total++;
        if (waits2 != 48 * CLK_DIV + GAP_CYC - 2) begin
            bad++;
            $display("[TB] FAIL b2b_second_waits got=%0d want=%0d", waits2, 48 * CLK_DIV + GAP_CYC - 2);
        end
        waitIdle("b2b");
        total++;
        if (frames.size() != 2 || frames[0] !== 24'h110001 || frames[1] !== 24'h120002) begin
            bad++;
            $display("[TB] FAIL b2b_frames count=%0d got0=%h got1=%h want=110001/120002",
                     frames.size(), (frames.size() > 0) ? frames[0] : 24'h0,
                     (frames.size() > 1) ? frames[1] : 24'h0);
        end
        total++;
        if (gapLow < int'(GAP_CYC + CLK_DIV)) begin
            bad++;
            $display("[TB] FAIL b2b_gap got=%0d want>=%0d", gapLow, GAP_CYC + CLK_DIV);
        end
        apbRead(16'h0000, rd, err);
        total++;
        if (rd !== 16'h0013) begin
            bad++;
            $display("[TB] FAIL b2b_addr got=%h want=0013", rd);
        end
    endtask

    task automatic test_wrap_miso();
        logic [15:0] rd;
        logic        err;
        int          waits;
        apbWrite(16'h0000, 16'h00FF, waits, err);
        frames.delete(); bitCnt = 0;
        misoShift = 24'h00BEEF;
        MISO = misoShift[23];
        apbWrite(16'h0001, 16'h1234, waits, err);
        waitIdle("wrap");
        total++;
        if (frames.size() != 1 || frames[0] !== 24'hFF1234) begin
            bad++;
            $display("[TB] FAIL wrap_frame count=%0d got=%h want=ff1234",
                     frames.size(), (frames.size() > 0) ? frames[0] : 24'h0);
        end
        apbRead(16'h0003, rd, err);
        total++;
        if (rd !== 16'hBEEF) begin
            bad++;
            $display("[TB] FAIL rx_value got=%h want=beef", rd);
        end
        apbRead(16'h0000, rd, err);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL addr_wrap got=%h want=0000", rd);
        end
    endtask

    task automatic test_error();
        logic [15:0] rd;
        logic        err;
        int          waits;
        apbWrite(16'h0000, 16'h0055, waits, err);
        apbWrite(16'h0004, 16'h00AA, waits, err);
        total++;
        if (err !== 1'b1 || waits != 0) begin
            bad++;
            $display("[TB] FAIL err_write slverr=%b waits=%0d want=1/0", err, waits);
        end
        apbRead(16'h0004, rd, err);
        total++;
        if (err !== 1'b1 || rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL err_read slverr=%b data=%h want=1/0000", err, rd);
        end
        apbRead(16'h0000, rd, err);
        total++;
        if (rd !== 16'h0055 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_no_change addr=%h slverr=%b want=0055/0", rd, err);
        end
        total++;
        if (PSLERR !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_idle_slverr got=%b want=0", PSLERR);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] rd;
        logic        err;
        int          waits;
        int          n = 0;
        frames.delete(); bitCnt = 0;
        misoShift = 24'hFFFFFF; MISO = 1'b1;
        apbWrite(16'h0001, 16'hF0F0, waits, err);
        while (bitCnt < 10 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (bitCnt < 10) begin
            bad++;
            $display("[TB] FAIL midframe_timeout bits=%0d want=10", bitCnt);
        end
        #1 RST = 1'b0;
        #1;
        total++;
        if ({SCLK, MOSI, BUSY, PROG, BRSTn} !== 5'b00001) begin
            bad++;
            $display("[TB] FAIL midframe_abort got=%b want=00001", {SCLK, MOSI, BUSY, PROG, BRSTn});
        end
        @(negedge CLK);
        RST = 1'b1;
        bitCnt = 0;
        apbRead(16'h0000, rd, err);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL midframe_addr got=%h want=0000", rd);
        end
        apbRead(16'h0003, rd, err);
        total++;
        if (rd !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL midframe_rx got=%h want=0000", rd);
        end
    endtask

    initial begin
        RST = 1'b0; PSel = 1'b0; PEnable = 1'b0; PWrite = 1'b0;
        PAddress = '0; PWData = '0; MISO = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_wrap_miso();
        test_error();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
